alu_uart_interface: RTL

//  Sequencer between the UART receiver/transmitter and the combinational ALU.
//  - Collects three received bytes in order: operand A, operand B, opcode.
//  - Holds them as registered ALU inputs.
//  - Captures the ALU result and hands it to the UART transmitter as one byte.
//  - Sits at top level: rx -> this block -> ALU (a,b,op -> w) -> this block -> tx.

---
 rtl/alu_uart_interface_pkg.sv | 28 ++
 rtl/alu_uart_interface_alu.sv | 32 +++
 rtl/alu_uart_interface.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART <-> ALU sequencer and the ALU beside it.
//  - Opcode constants (8-bit encodings, cast to the data width by users).
//  - Sequencer FSM state type, 3-bit, WAIT_A=0 .. WAIT_TX=4.
//  - is_busy(): states in which received bytes cannot be accepted.
package alu_uart_interface_pkg;

   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_SRA = 8'h03;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_NOR = 8'h27;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == SEND) || (s == WAIT_TX);
   endfunction

endpackage

// File: rtl/alu_uart_interface_alu.sv
// Combinational ALU instantiated beside alu_uart_interface at top level.
// Ports:
//  a, b  in  DATA_WIDTH  operands
//  op    in  DATA_WIDTH  opcode; unknown opcodes give w = 0
//  w     out DATA_WIDTH  result (wraps to DATA_WIDTH; shifts use b as amount)
module alu
   import alu_uart_interface_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] op,
   output logic [DATA_WIDTH-1:0] w
);

   always_comb begin
      w = '0;
      case (op)
         DATA_WIDTH'(OP_ADD): w = a + b;
         DATA_WIDTH'(OP_SUB): w = a - b;
         DATA_WIDTH'(OP_AND): w = a & b;
         DATA_WIDTH'(OP_OR):  w = a | b;
         DATA_WIDTH'(OP_XOR): w = a ^ b;
         DATA_WIDTH'(OP_SRA): w = DATA_WIDTH'($signed(a) >>> b);
         DATA_WIDTH'(OP_SRL): w = a >> b;
         DATA_WIDTH'(OP_NOR): w = ~(a | b);
         default:             w = '0;
      endcase
   end

endmodule

// File: rtl/alu_uart_interface.sv
// Sequencer between UART rx/tx and the combinational ALU.
// Collects operand A, operand B and opcode from the receiver, presents them as
// registered ALU inputs, captures the ALU result one cycle later and starts the
// transmitter with it.
// Ports:
//  clk, reset     clock; synchronous active-high reset
//  rx_done_tick   one-cycle pulse, rx_data valid
//  rx_data        received byte
//  tx_done_tick   one-cycle pulse, transmitter finished
//  alu_result     combinational ALU output for alu_a/alu_b/alu_op
//  alu_a/b/op     registered ALU inputs
//  tx_start       one-cycle pulse, transmit tx_data
//  tx_data        registered result byte
//  busy           high while a result is being sent (SEND, WAIT_TX)
//  rx_overrun     sticky flag: byte received while busy; cleared by reset only
module alu_uart_interface
   import alu_uart_interface_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_done_tick,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  tx_done_tick,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [DATA_WIDTH-1:0] alu_op,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy,
   output logic                  rx_overrun
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [DATA_WIDTH-1:0] alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic                  rx_overrun_q, rx_overrun_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_A;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      rx_overrun_d = rx_overrun_q;

      case (state_q)
         WAIT_A: begin
            if (rx_done_tick) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data;
               state_d  = SEND;
            end
         end
         SEND: begin
            // ALU inputs have been stable for a full cycle; result is valid here.
            tx_data_d  = alu_result;
            tx_start_d = 1'b1;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done_tick) begin
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase

      // A byte arriving while busy is dropped, including one coinciding with
      // tx_done_tick: the FSM only returns to WAIT_A after that edge.
      if (rx_done_tick && is_busy(state_q)) begin
         rx_overrun_d = 1'b1;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign rx_overrun = rx_overrun_q;
   assign busy       = is_busy(state_q);

endmodule
